// File: rtl/regfile_pkg.sv
// Shared constants, register types and the round-robin search helper
// for the register-file writeback arbiter.
package regfile_pkg;

    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Search req upward from ptr, wrapping at n (n <= 4).
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr,
                                           input int unsigned n);
        logic [2:0]  r;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = (32'(ptr) + k) % n;
            if (k < n && !r[2] && req[idx[1:0]])
                r = {1'b1, idx[1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr, and ptr moves
// just past the winner whenever a grant is actually taken (Adv).
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic [N-1:0] Req,
    input  logic         Adv,
    output logic [N-1:0] Gnt
);

    logic [1:0] ptr_q, ptr_d;
    logic [3:0] req4;
    logic [2:0] pick;

    // Combinational grant; depends only on Req and ptr, never on Gnt.
    always_comb begin
        req4 = '0;
        req4[N-1:0] = Req;
        pick = rr_pick(req4, ptr_q, N);
        for (int i = 0; i < N; i++)
            Gnt[i] = pick[2] && (pick[1:0] == 2'(i));
    end

    // Next pointer: one past the winner on a taken grant, else hold.
    always_comb begin
        ptr_d = ptr_q;
        if (Adv && pick[2])
            ptr_d = (pick[1:0] == 2'(N-1)) ? 2'd0 : pick[1:0] + 2'd1;
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 16x16 register file: round-robin share of the
// single write port, one registered output stage, and a pending-write
// scoreboard for hazard stalls.
// Optional: REGFILE_ZERO_REG_EN makes register 0 hardwired zero (requests
// to it are handshaked but never raise Write).
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4
) (
    input  logic                        CLK,
    input  logic                        Reset,
    input  logic                        Hold,
    input  logic [NUM_REQ-1:0]          ReqValid,
    input  logic [NUM_REQ*ADDR_W-1:0]   ReqAddr,
    input  logic [NUM_REQ*DATA_W-1:0]   ReqData,
    input  logic [NUM_REQ-1:0]          ReqCR,
    output logic [NUM_REQ-1:0]          ReqReady,
    output logic                        Write,
    output logic                        CRWrite,
    output logic [ADDR_W-1:0]           WriteAddr,
    output logic [DATA_W-1:0]           DataIn,
    output logic [(1<<ADDR_W)-1:0]      Pending
);
    import regfile_pkg::*;

    logic [NUM_REQ-1:0] req_elig, gnt;
    logic               xfer, wr_ok, cr_sel;
    logic [ADDR_W-1:0]  addr_sel, addr_q, addr_d;
    logic [DATA_W-1:0]  data_sel, data_q, data_d;
    logic               write_q, write_d, cr_q, cr_d;

    // No grants while held or in reset.
    assign req_elig = (Reset || Hold) ? '0 : ReqValid;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .CLK   (CLK),
        .Reset (Reset),
        .Req   (req_elig),
        .Adv   (xfer),
        .Gnt   (gnt)
    );

    assign ReqReady = gnt;
    assign xfer     = |(ReqValid & gnt);

    // Payload mux for the (one-hot) granted requester.
    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        cr_sel   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                addr_sel = ReqAddr[i*ADDR_W +: ADDR_W];
                data_sel = ReqData[i*DATA_W +: DATA_W];
                cr_sel   = ReqCR[i];
            end
        end
`ifdef REGFILE_ZERO_REG_EN
        wr_ok = (addr_sel != '0);
`else
        wr_ok = 1'b1;
`endif
    end

    // Output stage next state: address/data hold when idle.
    always_comb begin
        write_d = 1'b0;
        cr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (xfer) begin
            write_d = wr_ok;
            cr_d    = wr_ok && cr_sel;
            addr_d  = addr_sel;
            data_d  = data_sel;
        end
    end

    // Output stage registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            write_q <= 1'b0;
            cr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            write_q <= write_d;
            cr_q    <= cr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // A write staged when Reset arrives is dropped, so enables are masked.
    assign Write     = write_q && !Reset;
    assign CRWrite   = cr_q && !Reset;
    assign WriteAddr = addr_q;
    assign DataIn    = data_q;

    // Pending scoreboard: one-hot of the address being written.
    always_comb begin
        Pending = '0;
        if (Write) Pending[addr_q] = 1'b1;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 16x16-bit register file (regFile16b16) between NUM_REQ writeback requesters, e.g. ALU result, memory load and control-register update.
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered output stage drives the register file's Write, CRWrite, WriteAddr and DataIn.
- Exports a pending-write scoreboard that the control unit uses for hazard stalls.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..4).
- DATA_W, 16, register data width.
- ADDR_W, 4, register address width (16 registers).

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Hold  input  1  when 1, no new grants are issued; the output stage still drains.
- ReqValid  input  NUM_REQ  per-requester write request.
- ReqAddr  input  NUM_REQ*ADDR_W  packed destination register; requester i occupies bits [i*ADDR_W +: ADDR_W].
- ReqData  input  NUM_REQ*DATA_W  packed write data.
- ReqCR  input  NUM_REQ  request also loads the CR shadow (drives CRWrite).
- ReqReady  output  NUM_REQ  one-hot grant; transfer occurs when ReqValid[i] and ReqReady[i] are both 1.
- Write  output  1  register file write enable.
- CRWrite  output  1  register file CR write enable.
- WriteAddr  output  ADDR_W  register file write address.
- DataIn  output  DATA_W  register file write data.
- Pending  output  16  bit r = 1 while a write to register r sits in the output stage.

Behaviour:
- Reset (synchronous, Reset=1 at a CLK edge):
  - Write, CRWrite, WriteAddr, DataIn and Pending all go to 0.
  - Round-robin pointer goes to 0.
  - ReqReady is forced to 0 during any cycle in which Reset=1.
  - Reset mid-transfer discards the staged write; the register file is not written that cycle.
- Arbitration (combinational, cycle N):
  - If Hold=0 and any ReqValid is set, grant the first valid requester searching from pointer ptr upward and wrapping at NUM_REQ.
  - ReqReady is one-hot or all-zero. ReqReady never depends on ReqReady itself, so there are no loops.
- Pointer update: on a transfer by requester g, ptr <= (g+1) mod NUM_REQ. With no transfer, ptr holds.
- Output stage (registered):
  - On a transfer in cycle N, cycle N+1 shows Write=1, WriteAddr=ReqAddr[g], DataIn=ReqData[g], CRWrite=ReqCR[g].
  - The register file captures at the end of cycle N+1. Latency is 1 cycle from handshake to Write.
  - With no transfer in cycle N, cycle N+1 shows Write=0 and CRWrite=0; WriteAddr and DataIn hold their previous values.
  - The stage accepts a new transfer every cycle, so throughput is 1 write per cycle.
- CRWrite is only ever 1 together with Write=1.
- Pending = one-hot(WriteAddr) when Write=1, else 0.
- Starvation bound: a requester holding ReqValid with Hold=0 is granted within NUM_REQ cycles.
- Requester rules:
  - A requester must keep ReqValid, ReqAddr, ReqData and ReqCR stable until it is granted.
  - Deasserting ReqValid before grant is legal and discards that request.
- Hold=1 together with ReqValid: no grant, ptr unchanged, and the cycle after shows Write=0.
- All-same-address writes from different requesters are serialised in grant order; the last granted value wins.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired zero.
  - A request with ReqAddr=0 is still handshaked and advances ptr.
  - Its output cycle shows Write=0, CRWrite=0 and Pending[0]=0.
- Undefined: address 0 is written like any other register.

Decomposition:
- Package regfile_pkg holds:
  - constants NUM_REGS=16, DATA_W=16, ADDR_W=4;
  - typedef reg_addr_t (4 bits) and reg_data_t (16 bits);
  - the round-robin helper function.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs Req[N], Adv, CLK, Reset;
  - output Gnt[N], one-hot;
  - holds ptr.
- regfile_wb_arbiter instantiates rr_arbiter and adds the mux, the output register and the scoreboard.

Test Plan:
- Reset: apply Reset=1 for 2 cycles with all ReqValid=1.
  - Expect ReqReady=000, Write=0, Pending=0 throughout.
  - After release, the first grant goes to requester 0.
- Single request: req1 sends addr 5, data 16'h00A5.
  - ReqReady=010 in cycle N.
  - Cycle N+1 shows Write=1, WriteAddr=5, DataIn=16'h00A5, Pending=16'h0020.
  - A regFile16b16 read of register 5 returns 16'h00A5 afterwards.
- Contention: all three requesters hold valid for 6 cycles.
  - Grants are 001, 010, 100, 001, 010, 100.
  - Write=1 every cycle from the second cycle on.
- CR path: req2 sends ReqCR=1, addr 8, data 16'h0008.
  - Cycle N+1 shows Write=1 and CRWrite=1.
  - ReadDataCR=16'h0008 after the edge.
- Hold: Hold=1 for 3 cycles with req0 valid.
  - No grant and Write=0 during Hold.
  - Grant to req0 in the first cycle after Hold drops.
- Zero register with REGFILE_ZERO_REG_EN defined: req0 writes addr 0 with data 16'hFFFF.
  - Handshake completes and ptr advances.
  - Write=0 in cycle N+1; register 0 still reads 16'h0000.
